// File: rtl/pixel_feeder.sv
// Streaming pixel source for the 3x3 line-buffer controller: reads a greyscale frame row-major,
// primes PRIME_LINES lines, then sends one line per line_req credit. Optional BORDER_PAD_EN adds zero lines.
module pixel_feeder #(
  parameter int IMG_WIDTH   = 256,
  parameter int IMG_HEIGHT  = 256,
  parameter int PRIME_LINES = 4,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              line_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_out_valid,
  output logic              busy,
  output logic              done
);

`ifdef BORDER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int TOTAL_LINES = IMG_HEIGHT + (PAD_EN ? 2 : 0);
  localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int LINE_W      = $clog2(TOTAL_LINES + 1);

  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(TOTAL_LINES - 1);
  localparam logic [2:0]        CREDIT_INIT = 3'(PRIME_LINES);
  localparam logic [2:0]        CREDIT_MAX  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_FLUSH} state_e;

  state_e             state_q;
  logic [COL_W-1:0]   col_q;
  logic [LINE_W-1:0]  line_q;
  logic [2:0]         credits_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               rd_en_q;
  logic               valid_q;
  logic               pad_q;
  logic               busy_q;
  logic               done_q;
  logic               req_q;

  logic               credit_evt;
  logic [2:0]         credits_inc;
  logic [2:0]         credits_end;
  logic [LINE_W-1:0]  line_nxt;
  logic               cur_pad;
  logic               line_end;
  logic               last_line;

  function automatic logic is_pad(input logic [LINE_W-1:0] ln);
    return PAD_EN && ((ln == '0) || (ln == LINE_LAST));
  endfunction

  // A request edge only earns a credit while a frame is in flight.
  always_comb begin
    credit_evt  = line_req && !req_q && (state_q != S_IDLE);
    credits_inc = (credit_evt && (credits_q != CREDIT_MAX)) ? credits_q + 3'd1 : credits_q;
    credits_end = credit_evt ? credits_q : credits_q - 3'd1;
    line_nxt    = line_q + LINE_W'(1);
    cur_pad     = is_pad(line_q);
    line_end    = (col_q == COL_LAST);
    last_line   = (line_q == LINE_LAST);
  end

  // NOTE: the async reset clears every control register; the frame memory itself lives outside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      line_q    <= '0;
      credits_q <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      pad_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      req_q   <= line_req;
      done_q  <= 1'b0;
      valid_q <= (state_q == S_STREAM);
      pad_q   <= (state_q == S_STREAM) && cur_pad;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_STREAM;
            credits_q <= CREDIT_INIT;
            line_q    <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= !is_pad('0);
          end
        end

        S_STREAM: begin
          if (!cur_pad) addr_q <= addr_q + ADDR_W'(1);
          if (line_end) begin
            col_q     <= '0;
            line_q    <= line_nxt;
            credits_q <= credits_end;
            if (last_line) begin
              state_q <= S_FLUSH;
              rd_en_q <= 1'b0;
            end else if (credits_end == 3'd0) begin
              state_q <= S_WAIT;
              rd_en_q <= 1'b0;
            end else begin
              rd_en_q <= !is_pad(line_nxt);
            end
          end else begin
            col_q     <= col_q + COL_W'(1);
            credits_q <= credits_inc;
          end
        end

        S_WAIT: begin
          credits_q <= credits_inc;
          if (credit_evt) begin
            state_q <= S_STREAM;
            rd_en_q <= !cur_pad;
          end
        end

        S_FLUSH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory data arrives one cycle after its strobe, aligned with the delayed qualifier.
  assign pixel_out       = (valid_q && !pad_q) ? mem_rd_data : 8'd0;
  assign pixel_out_valid = valid_q;
  assign mem_rd_en       = rd_en_q;
  assign mem_addr        = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
